// File: rtl/breakout_pkg.sv
// -----------------------------------------------------------------------------
// breakout_pkg
//   Shared constants for the 160x120 breakout video path: screen geometry,
//   the 3-bit colour codes, default paddle geometry, the paddle drawer's state
//   encoding and a small helper that clamps a left-edge X onto the screen.
// -----------------------------------------------------------------------------
package breakout_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    localparam int DEF_PADDLE_W = 16;
    localparam int DEF_PADDLE_H = 2;
    localparam int DEF_PADDLE_Y = 116;

    // Paddle drawer states (also exported on the debug state port).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest legal left edge is passed in so the caller owns the geometry.
    function automatic logic [7:0] clamp_x(input logic [7:0] x, input logic [7:0] max_x);
        return (x > max_x) ? max_x : x;
    endfunction

endpackage

// File: rtl/paddle_draw_rect_scanner.sv
// -----------------------------------------------------------------------------
// rect_scanner
//   Walks a RECT_W x RECT_H rectangle in raster order (column inner, row outer)
//   and emits one registered pixel coordinate per cycle.
//   A start pulse loads the base corner; the first pixel is presented in the
//   cycle right after the start edge. A start while scanning restarts the walk.
// Ports
//   clk, resetn       clock, asynchronous active-low reset
//   i_start           load base and begin a new scan
//   i_base_x/y        top-left corner of the rectangle
//   o_x, o_y          current pixel coordinate
//   o_valid           o_x/o_y hold a pixel of the current scan
//   o_last            current pixel is the final one of the scan
// -----------------------------------------------------------------------------
module rect_scanner #(
    parameter int RECT_W = 16,
    parameter int RECT_H = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_start,
    input  logic [7:0] i_base_x,
    input  logic [6:0] i_base_y,
    output logic [7:0] o_x,
    output logic [6:0] o_y,
    output logic       o_valid,
    output logic       o_last
);

    localparam logic [7:0] COL_MAX = 8'(RECT_W - 1);
    localparam logic [3:0] ROW_MAX = 4'(RECT_H - 1);
    localparam logic       SINGLE  = (RECT_W == 1) && (RECT_H == 1);

    logic [7:0] r_base_x;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [7:0] r_col;
    logic [3:0] r_row;
    logic       r_valid;
    logic       r_last;

    logic       w_wrap;
    logic [7:0] w_next_col;
    logic [3:0] w_next_row;
    logic       w_next_last;

    always_comb begin
        w_wrap      = (r_col == COL_MAX);
        w_next_col  = w_wrap ? 8'd0 : r_col + 8'd1;
        w_next_row  = w_wrap ? r_row + 4'd1 : r_row;
        // Precompute "last" one pixel ahead so o_last lines up with o_x/o_y.
        w_next_last = (w_next_col == COL_MAX) && (w_next_row == ROW_MAX);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base_x <= 8'd0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_col    <= 8'd0;
            r_row    <= 4'd0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
        end else if (i_start) begin
            r_base_x <= i_base_x;
            r_x      <= i_base_x;
            r_y      <= i_base_y;
            r_col    <= 8'd0;
            r_row    <= 4'd0;
            r_valid  <= 1'b1;
            r_last   <= SINGLE;
        end else if (r_valid) begin
            if (r_last) begin
                // Scan complete; coordinates hold their final value.
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_col  <= w_next_col;
                r_row  <= w_next_row;
                r_x    <= w_wrap ? r_base_x : r_x + 8'd1;
                r_y    <= w_wrap ? r_y + 7'd1 : r_y;
                r_last <= w_next_last;
            end
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/paddle_draw.sv
// -----------------------------------------------------------------------------
// paddle_draw
//   Redraws the paddle on the 160x120 VGA adapter. On a frame tick while idle
//   it clamps the requested left edge, and if the paddle moved (or has never
//   been drawn) erases the old rectangle and draws the new one, one pixel per
//   cycle on the plot bus. All outputs come straight from registers.
// Ports
//   clk, resetn   clock, asynchronous active-low reset
//   paddle_x      requested left edge (sampled only on an accepted tick)
//   frame_tick    one-cycle pulse per frame; ignored unless idle
//   vga_x/y       pixel coordinate to the adapter
//   vga_colour    pixel colour
//   vga_plot      write strobe, one pixel per high cycle
//   busy          high while erasing or drawing
//   done          one-cycle pulse after the final pixel of an update
//   dbg_state     current FSM state, for observation only
// -----------------------------------------------------------------------------
module paddle_draw
    import breakout_pkg::*;
#(
    parameter int         PADDLE_W  = DEF_PADDLE_W,
    parameter int         PADDLE_H  = DEF_PADDLE_H,
    parameter int         PADDLE_Y  = DEF_PADDLE_Y,
    parameter logic [2:0] FG_COLOUR = COLOUR_WHITE,
    parameter logic [2:0] BG_COLOUR = COLOUR_BLACK
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] paddle_x,
    input  logic       frame_tick,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done,
    output state_t     dbg_state
);

    localparam logic [7:0] MAX_X   = 8'(SCREEN_W - PADDLE_W);
    localparam logic [7:0] START_X = 8'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [6:0] TOP_Y   = 7'(PADDLE_Y);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_last_x;
    logic [7:0] r_new_x;
    logic       r_drawn;
    logic [2:0] r_colour;

    logic [7:0] w_clamped_x;
    logic       w_start;
    logic [7:0] w_start_x;
    logic [2:0] w_start_colour;
    logic       w_load_new;
    logic       w_commit;

    logic [7:0] w_scan_x;
    logic [6:0] w_scan_y;
    logic       w_scan_valid;
    logic       w_scan_last;

    assign w_clamped_x = clamp_x(paddle_x, MAX_X);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_start        = 1'b0;
        w_start_x      = r_new_x;
        w_start_colour = FG_COLOUR;
        w_load_new     = 1'b0;
        w_commit       = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_tick) begin
                    if (!r_drawn) begin
                        w_next_state = DRAW;
                        w_start      = 1'b1;
                        w_start_x    = w_clamped_x;
                        w_load_new   = 1'b1;
                    end else if (w_clamped_x != r_last_x) begin
                        w_next_state   = ERASE;
                        w_start        = 1'b1;
                        w_start_x      = r_last_x;
                        w_start_colour = BG_COLOUR;
                        w_load_new     = 1'b1;
                    end
                end
            end
            ERASE: begin
                // Restart the scanner on the erase's final pixel so the first
                // draw pixel follows with no gap cycle.
                if (w_scan_valid && w_scan_last) begin
                    w_next_state = DRAW;
                    w_start      = 1'b1;
                    w_start_x    = r_new_x;
                end
            end
            DRAW: begin
                if (w_scan_valid && w_scan_last) begin
                    w_next_state = DONE;
                    w_commit     = 1'b1;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_x <= START_X;
            r_new_x  <= 8'd0;
            r_drawn  <= 1'b0;
            r_colour <= 3'b000;
        end else begin
            if (w_load_new) begin
                r_new_x <= w_clamped_x;
            end
            if (w_commit) begin
                r_last_x <= r_new_x;
                r_drawn  <= 1'b1;
            end
            // Colour is captured on the same edge the scanner loads, so it
            // stays aligned with the pixel stream.
            if (w_start) begin
                r_colour <= w_start_colour;
            end
        end
    end

    rect_scanner #(
        .RECT_W (PADDLE_W),
        .RECT_H (PADDLE_H)
    ) u_scanner (
        .clk      (clk),
        .resetn   (resetn),
        .i_start  (w_start),
        .i_base_x (w_start_x),
        .i_base_y (TOP_Y),
        .o_x      (w_scan_x),
        .o_y      (w_scan_y),
        .o_valid  (w_scan_valid),
        .o_last   (w_scan_last)
    );

    assign vga_x      = w_scan_x;
    assign vga_y      = w_scan_y;
    assign vga_colour = r_colour;
    assign vga_plot   = w_scan_valid;
    assign busy       = (r_state == ERASE) || (r_state == DRAW);
    assign done       = (r_state == DONE);
    assign dbg_state  = r_state;

endmodule
